// File: rtl/iir_bp_pkg.sv
// Shared types and width constants for the cascaded bandpass IIR.
package iir_bp_pkg;
  typedef enum logic [1:0] {
    MODE_BP  = 2'b00,
    MODE_HP  = 2'b01,
    MODE_LP  = 2'b10,
    MODE_BYP = 2'b11
  } mode_t;

  typedef enum logic [1:0] {ST_IDLE, ST_HP, ST_LP, ST_OUT} state_t;

  // Differences carry two guard bits; coefficients get one zero sign bit.
  localparam int DIFF_GUARD = 2;
  localparam int SIGN_PAD   = 1;
endpackage

// File: rtl/iir_bp_mac.sv
// y = sat(add + round_half_up(coef * d)), coef unsigned Q0.COEF_W.
module iir_bp_mac
  import iir_bp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16
) (
  input  logic signed [DATA_W+DIFF_GUARD-1:0] d,
  input  logic        [COEF_W-1:0]            coef,
  input  logic signed [DATA_W-1:0]            add,
  output logic        [DATA_W-1:0]            y
);
  localparam int PW = DATA_W + DIFF_GUARD + COEF_W + SIGN_PAD;
  localparam logic signed [PW-1:0] HALF = PW'(1) <<< (COEF_W - 1);
  localparam logic signed [PW-1:0] MAXV = (PW'(1) <<< (DATA_W - 1)) - PW'(1);
  localparam logic signed [PW-1:0] MINV = -MAXV - PW'(1);

  logic signed [PW-1:0] prod, rnd, sum;

  always_comb begin
    prod = d * $signed({1'b0, coef});
    rnd  = (prod + HALF) >>> COEF_W;
    sum  = rnd + PW'(add);
    if (sum > MAXV)      y = {1'b0, {(DATA_W-1){1'b1}}};
    else if (sum < MINV) y = {1'b1, {(DATA_W-1){1'b0}}};
    else                 y = sum[DATA_W-1:0];
  end
endmodule

// File: rtl/iir_bandpass_cascade.sv
// Cascade of first-order HP/LP pairs, one section per cycle through a shared MAC.
module iir_bandpass_cascade
  import iir_bp_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int N_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  input  logic [1:0]                  mode,
  input  logic                        cfg_we,
  input  logic [$clog2(N_STAGES):0]   cfg_sel,
  input  logic [COEF_W-1:0]           cfg_data,
  input  logic                        hist_clr,
  output logic                        cfg_err
);
  localparam int IW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int DW = DATA_W + DIFF_GUARD;

  state_t                    state;
  mode_t                     md;
  logic [IW-1:0]             s;
  logic signed [DATA_W-1:0]  x;
  logic signed [DATA_W-1:0]  xprev [N_STAGES];
  logic signed [DATA_W-1:0]  yhp   [N_STAGES];
  logic signed [DATA_W-1:0]  yl    [N_STAGES];
  logic [COEF_W-1:0]         coef_a [N_STAGES];
  logic [COEF_W-1:0]         coef_b [N_STAGES];

  logic [$clog2(N_STAGES):0] sel_stage;
  logic [IW-1:0]             sel_idx;
  logic                      sel_ok, hp_pass, lp_pass;
  logic signed [DW-1:0]      mac_d;
  logic [COEF_W-1:0]         mac_coef;
  logic signed [DATA_W-1:0]  mac_add;
  logic [DATA_W-1:0]         mac_y;

  assign sel_stage = cfg_sel >> 1;
  assign sel_idx   = IW'(sel_stage);
  assign sel_ok    = int'(sel_stage) < N_STAGES;
  assign hp_pass   = (md == MODE_LP) || (md == MODE_BYP);
  assign lp_pass   = (md == MODE_HP) || (md == MODE_BYP);

  // HP: a*(yhp + x - xprev); LP: yl + b*(x - yl)
  always_comb begin
    mac_d    = '0;
    mac_coef = '0;
    mac_add  = '0;
    if (state == ST_LP) begin
      mac_d    = DW'(x) - DW'(yl[s]);
      mac_coef = coef_b[s];
      mac_add  = yl[s];
    end else begin
      mac_d    = DW'(yhp[s]) + DW'(x) - DW'(xprev[s]);
      mac_coef = coef_a[s];
    end
  end

  iir_bp_mac #(.DATA_W(DATA_W), .COEF_W(COEF_W)) u_mac (
    .d(mac_d), .coef(mac_coef), .add(mac_add), .y(mac_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      md        <= MODE_BP;
      s         <= '0;
      x         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      cfg_err   <= 1'b0;
      for (int i = 0; i < N_STAGES; i++) begin
        xprev[i]  <= '0;
        yhp[i]    <= '0;
        yl[i]     <= '0;
        coef_a[i] <= '0;
        coef_b[i] <= '0;
      end
    end else begin
      cfg_err <= (state != ST_IDLE) && (cfg_we || hist_clr);
      case (state)
        ST_IDLE: begin
          if (cfg_we) begin
            if (!sel_ok)         cfg_err <= 1'b1;
            else if (cfg_sel[0]) coef_b[sel_idx] <= cfg_data;
            else                 coef_a[sel_idx] <= cfg_data;
          end
          if (hist_clr) begin
            for (int i = 0; i < N_STAGES; i++) begin
              xprev[i] <= '0;
              yhp[i]   <= '0;
              yl[i]    <= '0;
            end
          end
          if (in_valid) begin
            x        <= in_data;
            md       <= mode_t'(mode);
            s        <= '0;
            in_ready <= 1'b0;
            state    <= ST_HP;
          end
        end
        ST_HP: begin
          if (!hp_pass) begin
            xprev[s] <= x;
            yhp[s]   <= mac_y;
            x        <= mac_y;
          end
          state <= ST_LP;
        end
        ST_LP: begin
          if (!lp_pass) begin
            yl[s] <= mac_y;
            x     <= mac_y;
          end
          if (s == IW'(N_STAGES - 1)) state <= ST_OUT;
          else begin
            s     <= s + 1'b1;
            state <= ST_HP;
          end
        end
        ST_OUT: begin
          // First OUT cycle publishes the result, giving 2*N_STAGES+1 latency.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= x;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iir_bandpass_cascade.sv
// Scoreboard bench: single-stage DUT checked against a reference model, plus a 3-stage DUT for latency/addressing.
module tb_iir_bandpass_cascade;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, cfg_we, hist_clr, cfg_err;
  logic [15:0] in_data, cfg_data;
  logic signed [15:0] out_data;
  logic [1:0]  mode;
  logic [0:0]  cfg_sel;

  logic        in_valid3, in_ready3, out_valid3, out_ready3, cfg_we3, hist_clr3, cfg_err3;
  logic [15:0] in_data3, cfg_data3, out_data3;
  logic [1:0]  mode3;
  logic [2:0]  cfg_sel3;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int ma, mb, mxp, myh, myl;

  always #5 clk = ~clk;

  iir_bandpass_cascade #(.DATA_W(16), .COEF_W(16), .N_STAGES(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .mode(mode),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .hist_clr(hist_clr),
    .cfg_err(cfg_err)
  );

  iir_bandpass_cascade #(.DATA_W(16), .COEF_W(16), .N_STAGES(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3), .mode(mode3),
    .cfg_we(cfg_we3), .cfg_sel(cfg_sel3), .cfg_data(cfg_data3), .hist_clr(hist_clr3),
    .cfg_err(cfg_err3)
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int rmul(input int c, input int d);
    longint p;
    p = longint'(c) * longint'(d);
    return int'((p + 64'sd32768) >>> 16);
  endfunction

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int model(input int xin, input int m);
    int xv, y;
    xv = xin;
    if (m == 0 || m == 1) begin
      y = sat16(longint'(rmul(ma, myh + xv - mxp)));
      mxp = xv; myh = y; xv = y;
    end
    if (m == 0 || m == 2) begin
      y = sat16(longint'(myl) + longint'(rmul(mb, xv - myl)));
      myl = y; xv = y;
    end
    return xv;
  endfunction

  // Scoreboard pop on every output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      chk("out_q_nonempty", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("out_data", int'(out_data), exp_q.pop_front());
    end
  end

  task automatic send(input int d, input int m, input int expv);
    int t = 0;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    chk("in_ready_wait", int'(in_ready), 1);
    in_data = 16'(d);
    mode = 2'(m);
    in_valid = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (exp_q.size() > 0 && t < 200) begin @(negedge clk); t++; end
    chk("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic cfg(input int sel, input int d);
    cfg_we = 1'b1; cfg_sel = 1'(sel); cfg_data = 16'(d);
    @(negedge clk);
    cfg_we = 1'b0;
    chk("cfg_err_idle", int'(cfg_err), 0);
    if (sel == 0) ma = d; else mb = d;
  endtask

  task automatic hclr();
    hist_clr = 1'b1;
    @(negedge clk);
    hist_clr = 1'b0;
    chk("hclr_err_idle", int'(cfg_err), 0);
    mxp = 0; myh = 0; myl = 0;
  endtask

  initial begin
    int cyc, d, m, held;
    rst = 1'b1; in_valid = 0; in_data = 0; out_ready = 1; mode = 0;
    cfg_we = 0; cfg_sel = 0; cfg_data = 0; hist_clr = 0;
    in_valid3 = 0; in_data3 = 0; out_ready3 = 1; mode3 = 2'b11;
    cfg_we3 = 0; cfg_sel3 = 0; cfg_data3 = 0; hist_clr3 = 0;
    ma = 0; mb = 0; mxp = 0; myh = 0; myl = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_cfg_err", int'(cfg_err), 0);
    rst = 1'b0;
    @(negedge clk);

    // Bypass latency through three stages
    in_data3 = 16'd1234; in_valid3 = 1'b1;
    @(posedge clk);
    #1 in_valid3 = 1'b0;
    cyc = 0;
    while (!out_valid3 && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("byp3_latency", cyc, 7);
    chk("byp3_data", int'(out_data3), 1234);
    @(negedge clk);
    // Stage 3 does not exist in a 3-stage cascade
    cfg_we3 = 1'b1; cfg_sel3 = 3'b110; cfg_data3 = 16'h1234;
    @(negedge clk);
    cfg_we3 = 1'b0;
    chk("bad_stage_err", int'(cfg_err3), 1);
    @(negedge clk);
    chk("bad_stage_pulse", int'(cfg_err3), 0);

    // HP only, a = 0.5
    cfg(0, 16'h8000);
    send(1000, 1, 500);   void'(model(1000, 1));
    send(1000, 1, 250);   void'(model(1000, 1));
    send(1000, 1, 125);   void'(model(1000, 1));
    wait_done();

    // LP only, b = 0.5, then history clear
    cfg(1, 16'h8000);
    send(1000, 2, 500);   void'(model(1000, 2));
    send(1000, 2, 750);   void'(model(1000, 2));
    send(1000, 2, 875);   void'(model(1000, 2));
    wait_done();
    hclr();
    send(1000, 2, 500);   void'(model(1000, 2));
    wait_done();

    // Coefficient write in the same cycle as the sample: new b applies
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_data = 16'h4000; mb = 16'h4000;
    send(1000, 2, 625);   void'(model(1000, 2));
    cfg_we = 1'b0;
    wait_done();

    // Saturation corner, a just below 1.0
    hclr();
    cfg(0, 16'hFFFF);
    send(-32768, 1, model(-32768, 1));
    send(32767, 1, 32767); void'(model(32767, 1));
    wait_done();

    // Backpressure: output held, config rejected during wait
    out_ready = 1'b0;
    hclr();
    send(1000, 2, model(1000, 2));
    cyc = 0;
    while (!out_valid && cyc < 50) begin @(negedge clk); cyc++; end
    chk("bp_valid", int'(out_valid), 1);
    held = (exp_q.size() > 0) ? exp_q[0] : 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin cfg_we = 1'b1; cfg_sel = 1'b1; cfg_data = 16'hFFFF; end
      if (k == 3) hist_clr = 1'b1;
      @(negedge clk);
      cfg_we = 1'b0; hist_clr = 1'b0;
      chk("bp_held", int'(out_data), held);
      chk("bp_in_ready", int'(in_ready), 0);
      if (k == 1 || k == 3) chk("bp_cfg_err", int'(cfg_err), 1);
      if (k == 2 || k == 4) chk("bp_cfg_err_pulse", int'(cfg_err), 0);
    end
    out_ready = 1'b1;
    wait_done();
    send(1000, 2, model(1000, 2));
    wait_done();

    // Random coefficients, modes and samples against the model
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 0) begin
        wait_done();
        cfg(0, int'($urandom_range(0, 65535)));
        cfg(1, int'($urandom_range(0, 65535)));
        if (i % 12 == 0) hclr();
      end
      d = int'($urandom_range(0, 65535)) - 32768;
      m = int'($urandom_range(0, 3));
      send(d, m, model(d, m));
    end
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
